// File: rtl/wb_master_pkg.sv
// Shared definitions for the Wishbone command master: FSM encoding, timeout default, abort data.
// The optional timeout feature is enabled with WB_CMD_MASTER_TIMEOUT_EN.
package wb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_t;

    localparam int          TIMEOUT_CYCLES_DEFAULT = 255;
    localparam logic [31:0] ABORT_DATA             = 32'hFFFF_FFFF;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Counts BUS cycles without ack; expired flags the LIMIT-th such cycle so the FSM aborts at its end.
// Only instantiated when WB_CMD_MASTER_TIMEOUT_EN is defined.
module wb_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 16'd1;
        end
    end

    // cnt holds the number of ack-less cycles already elapsed, so this one is number cnt+1.
    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Command-to-Wishbone classic single-cycle initiator with registered outputs.
// Define WB_CMD_MASTER_TIMEOUT_EN to add the ack timeout and abort path.
module wb_cmd_master
    import wb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy_o,
    output logic [1:0]  dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the producer holds valid and its payload stable until that edge.
    wb_state_t state;
    logic      accept;

    assign accept      = cmd_valid_i && cmd_ready_o;
    assign busy_o      = (state != ST_IDLE);
    assign dbg_state_o = state;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    logic expired;

    wb_timeout_ctr #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n_i),
        .clr    (accept),
        .en     ((state == ST_BUS) && !wbm_ack_i),
        .expired(expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            rsp_err_o <= 1'b0;
        end else if ((state == ST_BUS) && !wbm_ack_i && expired) begin
            rsp_err_o <= 1'b1;
        end else if ((state == ST_RESP) && rsp_ready_i) begin
            rsp_err_o <= 1'b0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign rsp_err_o      = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state       <= ST_IDLE;
            cmd_ready_o <= 1'b0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Ready rises one cycle after entering IDLE, giving the 4-cycle command period.
                    cmd_ready_o <= 1'b1;
                    if (accept) begin
                        state       <= ST_BUS;
                        cmd_ready_o <= 1'b0;
                        wbm_cyc_o   <= 1'b1;
                        wbm_stb_o   <= 1'b1;
                        wbm_we_o    <= cmd_we_i;
                        wbm_sel_o   <= cmd_sel_i;
                        wbm_adr_o   <= cmd_adr_i;
                        wbm_dat_o   <= cmd_dat_i;
                    end
                end
                ST_BUS: begin
                    if (wbm_ack_i) begin
                        state       <= ST_RESP;
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        wbm_we_o    <= 1'b0;
                        wbm_sel_o   <= '0;
                        wbm_adr_o   <= '0;
                        wbm_dat_o   <= '0;
                        rsp_valid_o <= 1'b1;
                        rsp_dat_o   <= wbm_we_o ? 32'h0 : wbm_dat_i;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    end else if (expired) begin
                        state       <= ST_RESP;
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        wbm_we_o    <= 1'b0;
                        wbm_sel_o   <= '0;
                        wbm_adr_o   <= '0;
                        wbm_dat_o   <= '0;
                        rsp_valid_o <= 1'b1;
                        rsp_dat_o   <= ABORT_DATA;
`endif
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state       <= ST_IDLE;
                        rsp_valid_o <= 1'b0;
                        rsp_dat_o   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master (TIMEOUT_CYCLES = 8).
// Timeout expectations follow WB_CMD_MASTER_TIMEOUT_EN as seen by this file.
module tb_wb_cmd_master;

    localparam int         TO     = 8;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        cyc;
    logic        stb;
    logic        we_o;
    logic [3:0]  sel_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic        ack;
    logic [31:0] dat_i;
    logic        busy;
    logic [1:0]  dbg_state;

    int tests = 0;
    int fails = 0;

    wb_cmd_master #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_we_i   (cmd_we),
        .cmd_sel_i  (cmd_sel),
        .cmd_adr_i  (cmd_adr),
        .cmd_dat_i  (cmd_dat),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_dat_o  (rsp_dat),
        .rsp_err_o  (rsp_err),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we_o),
        .wbm_sel_o  (sel_o),
        .wbm_adr_o  (adr_o),
        .wbm_dat_o  (dat_o),
        .wbm_ack_i  (ack),
        .wbm_dat_i  (dat_i),
        .busy_o     (busy),
        .dbg_state_o(dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_cmd(input logic we, input logic [3:0] sel,
                             input logic [31:0] adr, input logic [31:0] dat);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_sel   = sel;
        cmd_adr   = adr;
        cmd_dat   = dat;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_sel   = '0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        rsp_ready = 1'b0;
        ack       = 1'b0;
        dat_i     = '0;

        // Reset state
        step();
        step();
        check("rst_state", 64'(dbg_state), 64'(S_IDLE));
        check("rst_ready", 64'(cmd_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_bus", 64'({cyc, stb, we_o, sel_o}), 64'd0);
        check("rst_adr_dat", {adr_o, dat_o}, 64'd0);
        check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_dat}), 64'd0);
        rst_n = 1'b1;
        step();
        check("rel_ready", 64'(cmd_ready), 64'd1);

        // Read, ack two cycles after stb
        drive_cmd(1'b0, 4'hF, 32'h1000_0010, 32'hDEAD_BEEF);
        rsp_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("rd_cycstb", 64'({cyc, stb}), 64'h3);
        check("rd_ready_low", 64'(cmd_ready), 64'd0);
        check("rd_busy", 64'(busy), 64'd1);
        check("rd_adr", 64'(adr_o), 64'h1000_0010);
        step();
        check("rd_cyc_hold", 64'({cyc, stb, we_o}), 64'h6);
        step();
        ack   = 1'b1;
        dat_i = 32'h1234_5678;
        step();
        ack   = 1'b0;
        dat_i = 32'h0BAD_0BAD;
        check("rd_rsp", 64'({rsp_valid, rsp_err, rsp_dat}), {31'd0, 1'b1, 1'b0, 32'h1234_5678});
        check("rd_cyc_drop", 64'({cyc, stb}), 64'd0);
        check("rd_state_resp", 64'(dbg_state), 64'(S_RESP));
        check("rd_adr_clear", 64'(adr_o), 64'd0);
        step();
        check("rd_idle", 64'({dbg_state, rsp_valid, cmd_ready, busy}), 64'd0);
        step();
        check("rd_ready_back", 64'(cmd_ready), 64'd1);

        // Write with stable bus outputs, response held under backpressure
        drive_cmd(1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_A5A5);
        rsp_ready = 1'b0;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wr_ctrl", 64'({cyc, stb, we_o, sel_o}), 64'h7F);
            check("wr_adr_dat", {adr_o, dat_o}, 64'h3000_0004_A5A5_A5A5);
            if (i == 2) begin
                ack   = 1'b1;
                dat_i = 32'h5555_AAAA;
            end
            step();
        end
        ack = 1'b0;
        check("wr_rsp", 64'({rsp_valid, rsp_err, rsp_dat}), {31'd0, 1'b1, 1'b0, 32'h0});

        drive_cmd(1'b0, 4'h3, 32'h2000_0008, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_hold", 64'({rsp_valid, rsp_err, rsp_dat}), {31'd0, 1'b1, 1'b0, 32'h0});
            check("bp_ready_low", 64'(cmd_ready), 64'd0);
            check("bp_state", 64'(dbg_state), 64'(S_RESP));
            ack   = (i == 2);
            dat_i = 32'hFFFF_0000;
            step();
        end
        ack = 1'b0;
        check("bp_ack_ignored", 64'({rsp_valid, rsp_dat, cyc}), {31'd0, 1'b1, 32'h0, 1'b0});
        rsp_ready = 1'b1;
        step();
        check("bp_idle_first", 64'({dbg_state, cmd_ready, rsp_valid}), 64'd0);
        step();
        check("bp_idle_ready", 64'({dbg_state, cmd_ready}), 64'h1);
        step();
        cmd_valid = 1'b0;
        check("bp_next_cmd", 64'({we_o, sel_o, adr_o}), {27'd0, 1'b0, 4'h3, 32'h2000_0008});
        check("bp_next_state", 64'(dbg_state), 64'(S_BUS));

        // Slave never acks
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            check("to_cyc_high", 64'({cyc, stb}), 64'h3);
            step();
        end
        check("to_cyc_drop", 64'({cyc, stb}), 64'd0);
        check("to_rsp", 64'({rsp_valid, rsp_err, rsp_dat}), {31'd0, 1'b1, 1'b1, 32'hFFFF_FFFF});
        check("to_adr_clear", 64'(adr_o), 64'd0);
        step();
        check("to_idle", 64'({dbg_state, rsp_valid, rsp_err}), 64'd0);
        step();
`else
        for (int i = 0; i < 3 * TO; i++) begin
            check("hang_cyc_high", 64'({cyc, stb, rsp_valid, rsp_err}), 64'hC);
            step();
        end
        ack   = 1'b1;
        dat_i = 32'h600D_0001;
        step();
        ack = 1'b0;
        check("hang_rsp", 64'({rsp_valid, rsp_err, rsp_dat}), {31'd0, 1'b1, 1'b0, 32'h600D_0001});
        step();
        step();
`endif
        check("to_ready_back", 64'(cmd_ready), 64'd1);

        // Ack on the expiry cycle
        drive_cmd(1'b0, 4'hF, 32'h4000_0000, 32'h0);
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < TO; i++) begin
            check("exp_cyc_high", 64'({cyc, stb}), 64'h3);
            if (i == TO - 1) begin
                ack   = 1'b1;
                dat_i = 32'hCAFE_F00D;
            end
            step();
        end
        ack = 1'b0;
        check("exp_ack_wins", 64'({rsp_valid, rsp_err, rsp_dat}), {31'd0, 1'b1, 1'b0, 32'hCAFE_F00D});
        step();
        step();
        check("exp_ready_back", 64'(cmd_ready), 64'd1);

        // Reset pulse mid-BUS
        drive_cmd(1'b1, 4'h1, 32'h5000_0000, 32'h0000_0001);
        step();
        cmd_valid = 1'b0;
        step();
        check("rb_in_bus", 64'({cyc, stb}), 64'h3);
        rst_n = 1'b0;
        step();
        check("rb_cyc_drop", 64'({cyc, stb, busy}), 64'd0);
        check("rb_state", 64'(dbg_state), 64'(S_IDLE));
        check("rb_outputs", 64'({rsp_valid, cmd_ready, we_o, sel_o}), 64'd0);
        rst_n = 1'b1;
        step();
        check("rb_ready_after", 64'({cmd_ready, rsp_valid}), 64'h2);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rb_no_rsp", 64'({rsp_valid, cyc, cmd_ready}), 64'h1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the number of BUS-state cycles without ack before abort (range 1..65535).
REQ-002 SHALL have port wb_clk_i  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port wb_rst_n_i  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports cmd_valid_i input 1, cmd_ready_o output 1: the command handshake.
REQ-005 SHALL have command fields cmd_we_i input 1, cmd_sel_i input 4, cmd_adr_i input 32 and cmd_dat_i input 32.
REQ-006 SHALL have ports rsp_valid_o output 1, rsp_ready_i input 1: the response handshake.
REQ-007 SHALL have response fields rsp_dat_o output 32 (read data) and rsp_err_o output 1 (timeout flag).
REQ-008 SHALL have Wishbone initiator outputs wbm_cyc_o 1, wbm_stb_o 1, wbm_we_o 1, wbm_sel_o 4, wbm_adr_o 32 and wbm_dat_o 32.
REQ-009 SHALL have Wishbone initiator inputs wbm_ack_i 1 and wbm_dat_i 32.
REQ-010 SHALL have port busy_o  output  1, high whenever the state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, BUS and RESP.
REQ-012 cmd_ready_o SHALL be 1 only in IDLE; a command is accepted at cycle T when cmd_valid_i and cmd_ready_o are both 1.
REQ-013 On acceptance at T, SHALL register we/sel/adr/dat, enter BUS, and drive wbm_cyc_o = wbm_stb_o = 1 from T+1.
REQ-014 In BUS, wbm_* outputs SHALL hold stable until ack or abort; Wishbone classic single cycle only, no pipelining or bursts.
REQ-015 When wbm_ack_i is sampled 1 in BUS at cycle A, SHALL drop cyc/stb at A+1, enter RESP and assert rsp_valid_o at A+1.
REQ-016 On a read ack, rsp_dat_o SHALL take wbm_dat_i sampled at A; on a write ack, rsp_dat_o SHALL be 0; rsp_err_o SHALL be 0.
REQ-017 The timeout counter SHALL clear on entry to BUS and increment each BUS cycle without ack.
REQ-018 When the counter reaches TIMEOUT_CYCLES, SHALL abort: drop cyc/stb, enter RESP, rsp_err_o = 1, rsp_dat_o = 32'hFFFF_FFFF.
REQ-019 If ack and timeout expiry coincide, ack SHALL win (normal response, rsp_err_o = 0).
REQ-020 wbm_ack_i SHALL be ignored outside BUS.
REQ-021 rsp_valid_o, rsp_dat_o and rsp_err_o SHALL hold stable in RESP until rsp_ready_i is 1; the state is then IDLE on the next cycle.
REQ-022 cmd_ready_o SHALL be 0 during the RESP handshake cycle; the minimum command-to-command period is 4 cycles.
REQ-023 wbm_dat_o, wbm_adr_o, wbm_sel_o and wbm_we_o SHALL be 0 in IDLE.

Reset
REQ-024 While wb_rst_n_i = 0 at a clock edge, SHALL enter IDLE.
REQ-025 Reset SHALL drive all outputs to 0 except cmd_ready_o, which is 1 from the first cycle after release.
REQ-026 Reset during BUS SHALL drop cyc/stb at the next edge; the in-flight command is discarded and produces no response.

Configuration
REQ-027 Macro WB_CMD_MASTER_TIMEOUT_EN SHALL control the timeout feature.
REQ-028 With the macro defined, the counter and abort path of REQ-017..REQ-019 SHALL be present.
REQ-029 Without the macro, the counter and abort path SHALL not be synthesised: BUS waits indefinitely for ack and rsp_err_o is tied to 0.

Structure
REQ-030 A shared package wb_master_pkg SHALL hold the FSM state encoding, the TIMEOUT_CYCLES default and the abort data constant 32'hFFFF_FFFF.
REQ-031 The timeout counter SHALL be a sub-module wb_timeout_ctr (inputs clr, en; output expired), instantiated only under WB_CMD_MASTER_TIMEOUT_EN.

Verification
REQ-032 Read with slave ack 2 cycles after stb, rsp_ready_i = 1, wbm_dat_i = 32'h1234_5678 -> rsp_valid_o 1 cycle after ack, rsp_dat_o = 32'h1234_5678, rsp_err_o = 0.
REQ-033 Write adr 32'h3000_0004, dat 32'hA5A5_A5A5, sel 4'hF -> wbm_* show those values for every cyc cycle; rsp_dat_o = 0.
REQ-034 Slave never acks, TIMEOUT_CYCLES = 8, macro defined -> cyc drops after 8 BUS cycles, rsp_err_o = 1, rsp_dat_o = 32'hFFFF_FFFF.
REQ-035 Ack on the expiry cycle -> normal response with rsp_err_o = 0.
REQ-036 rsp_ready_i held 0 for 5 cycles with cmd_valid_i = 1 -> response held stable, cmd_ready_o = 0 throughout, next command accepted only after IDLE.
REQ-037 wb_rst_n_i pulsed low mid-BUS -> cyc/stb = 0 next cycle, no rsp_valid_o, cmd_ready_o = 1 after release.
